hfosc_sequencer: RTL and testbench
==================================

Name: hfosc_sequencer

Overview:
- Sequences the iCE40 SB_HFOSC and the core clock-select mux from the PMU's clock request (clkhf_powerup / clkhf_enable).
- Sits directly downstream of the power management unit, and is clocked by the always-on low-frequency clock.
- Guarantees powerup → settle → switch ordering, and the reverse on shutdown.
- Holds the core across every clock-select change so the mux switch is glitch-free.

Parameters:
- PU_CYCLES, 4: clk cycles with CLKHFPU high before CLKHFEN is raised; must be ≥1.
- SETTLE_CYCLES, 8: clk cycles with CLKHFEN high before the core is switched to the HF clock; must be ≥1.
- CNT_W, 8: width of the internal wait counter; must hold max(PU_CYCLES, SETTLE_CYCLES).

Ports:
- clk, input, 1: always-on slow clock (LFOSC domain).
- reset, input, 1: synchronous, active-high reset.
- clkhf_powerup, input, 1: PMU HF powerup request; asynchronous to clk.
- clkhf_enable, input, 1: PMU HF enable request; asynchronous to clk.
- core_idle, input, 1: core has no outstanding memory transaction; asynchronous to clk.
- hf_pu, output, 1: drives SB_HFOSC CLKHFPU.
- hf_en, output, 1: drives SB_HFOSC CLKHFEN.
- hf_sel, output, 1: clock mux select; 1 = HF clock to core, 0 = slow clock.
- core_hold, output, 1: stall request to the core.
- busy, output, 1: high while the sequencer is in a transitional state.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; all registers clear on a clk edge with reset=1.
- Reset state: state=OFF, hf_pu=0, hf_en=0, hf_sel=0, core_hold=0, counter=0, synchronizer flops=0.
- Reset mid-operation: outputs drop to their reset values on the same edge, including from RUN.
- Request synchronizer:
  - req = clkhf_powerup & clkhf_enable passes through a 2-flop synchronizer to give req_s.
  - core_idle passes through its own 2-flop synchronizer to give idle_s.
  - Latency from an input change to its visibility in the FSM is 2 clk cycles.
- All outputs are registered and decoded from the state, with no combinational paths from inputs.
- busy = (state != OFF) && (state != RUN).
- States and transitions (counter cleared on every state entry):
  - OFF: all outputs 0. If req_s=1, go to PWRUP.
  - PWRUP: hf_pu=1. The counter increments each cycle.
    - When counter == PU_CYCLES-1, go to SETTLE.
    - If req_s=0, go to PWRDN (abort).
  - SETTLE: hf_pu=1, hf_en=1, core_hold=1.
    - When counter == SETTLE_CYCLES-1, go to RUN.
    - If req_s=0, go to PWRDN.
  - RUN: hf_pu=1, hf_en=1, hf_sel=1.
    - core_hold stays 1 for the first RUN cycle only, then 0.
    - If req_s=0, go to DRAIN.
  - DRAIN: hf_pu=1, hf_en=1, hf_sel=1, core_hold=1.
    - If req_s=1 again, return to RUN; hf_sel stays 1 and core_hold clears after one cycle.
    - Else, once idle_s=1, go to PWRDN.
  - PWRDN: hf_pu=1, hf_en=0, hf_sel=0, core_hold=1 for exactly one cycle, then go to OFF (hf_pu falls on OFF entry).
    - A req_s arriving during PWRDN is ignored until OFF.
    - Minimum OFF dwell is one cycle before PWRUP.
- Invariants:
  - hf_sel changes only in a cycle where core_hold=1.
  - hf_en=1 implies hf_pu=1.
  - hf_sel=1 implies hf_en=1.
- Abort rule: a drop of req_s in PWRUP or SETTLE wins over counter expiry in the same cycle and the FSM goes to PWRDN.
- The PMU request is level-sensitive. A request that stays high keeps the FSM in RUN indefinitely.
- Counter: CNT_W bits, saturating; it never wraps within a state.

Optional Feature:
- Macro: HFOSC_ONTIME_EN.
- With the macro defined:
  - Adds output port hf_ontime, 32 bits: free-running count of clk cycles spent with hf_en=1.
  - Cleared by reset and saturates at 32'hFFFFFFFF.
  - Adds input port ontime_clr, 1 bit: synchronous clear that takes priority over increment.
  - Used for energy accounting.
- Without the macro, neither port exists and no counter logic is instantiated.

Test Plan:
- Reset and hold request low for 20 cycles → all outputs 0 and busy=0 throughout.
- Power-on (PU_CYCLES=4, SETTLE_CYCLES=8): raise both requests at cycle 0 →
  - hf_pu rises at cycle 3.
  - hf_en rises at cycle 7.
  - hf_sel rises at cycle 15 with core_hold=1.
  - core_hold falls at cycle 16.
  - busy low from cycle 15.
- Shutdown from RUN: drop clkhf_enable, hold core_idle=0 for 10 cycles, then raise it →
  - core_hold rises 3 cycles after the drop; hf_sel stays 1 until idle_s=1.
  - Then hf_sel=0 and hf_en=0 together, and hf_pu=0 one cycle later.
- Abort in PWRUP: drop the request 2 cycles after hf_pu rises → PWRDN then OFF; hf_en never asserts.
- Re-request in DRAIN: raise the request while core_idle=0 → return to RUN; hf_sel never leaves 1; core_hold clears one cycle after re-entry.
- Reset mid-RUN: assert reset for 1 cycle → on the next edge hf_pu=hf_en=hf_sel=core_hold=0.
- With HFOSC_ONTIME_EN: hf_ontime equals the count of hf_en=1 cycles, and ontime_clr forces it to 0.

Source files
------------

// File: rtl/hfosc_sequencer_if.sv
// PMU-facing request/status bundle of the HF oscillator sequencer.
// master = PMU/core side driving requests, slave = the sequencer.
interface hfosc_sequencer_if;
  logic clkhf_powerup;
  logic clkhf_enable;
  logic core_idle;
  logic hf_pu;
  logic hf_en;
  logic hf_sel;
  logic core_hold;
  logic busy;

  modport master (
    output clkhf_powerup, clkhf_enable, core_idle,
    input  hf_pu, hf_en, hf_sel, core_hold, busy
  );

  modport slave (
    input  clkhf_powerup, clkhf_enable, core_idle,
    output hf_pu, hf_en, hf_sel, core_hold, busy
  );
endinterface

// File: rtl/hfosc_sequencer.sv
// SB_HFOSC powerup/settle/switch sequencer with glitch-free core clock select; optional HFOSC_ONTIME_EN on-time counter.
// Latency: 2 clk of request synchronization, then one registered FSM step; outputs are registered state decodes.
// No backpressure: the PMU request is level-sensitive, and core_hold stalls the core across every select change.
module hfosc_sequencer #(
  parameter int unsigned PU_CYCLES     = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  hfosc_sequencer_if.slave   bus
`ifdef HFOSC_ONTIME_EN
  ,
  input  logic               ontime_clr,
  output logic [31:0]        hf_ontime
`endif
);

  localparam logic [2:0] OFF    = 3'd0;
  localparam logic [2:0] PWRUP  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] PWRDN  = 3'd5;

  localparam logic [CNT_W-1:0] PU_LAST     = CNT_W'(PU_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic             req_m, req_s;
  logic             idle_m, idle_s;
  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_m  <= 1'b0;
      req_s  <= 1'b0;
      idle_m <= 1'b0;
      idle_s <= 1'b0;
    end else begin
      req_m  <= bus.clkhf_powerup & bus.clkhf_enable;
      req_s  <= req_m;
      idle_m <= bus.core_idle;
      idle_s <= idle_m;
    end
  end

  // A dropped request beats counter expiry while the oscillator is still warming up.
  always_comb begin
    nxt = state;
    case (state)
      OFF:     if (req_s) nxt = PWRUP;
      PWRUP:   if (!req_s) nxt = PWRDN;
               else if (cnt == PU_LAST) nxt = SETTLE;
      SETTLE:  if (!req_s) nxt = PWRDN;
               else if (cnt == SETTLE_LAST) nxt = RUN;
      RUN:     if (!req_s) nxt = DRAIN;
      DRAIN:   if (req_s) nxt = RUN;
               else if (idle_s) nxt = PWRDN;
      PWRDN:   nxt = OFF;
      default: nxt = OFF;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= OFF;
      cnt           <= '0;
      bus.hf_pu     <= 1'b0;
      bus.hf_en     <= 1'b0;
      bus.hf_sel    <= 1'b0;
      bus.core_hold <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      bus.hf_pu     <= (nxt != OFF);
      bus.hf_en     <= (nxt == SETTLE) || (nxt == RUN) || (nxt == DRAIN);
      bus.hf_sel    <= (nxt == RUN) || (nxt == DRAIN);
      bus.core_hold <= (nxt == SETTLE) || (nxt == DRAIN) || (nxt == PWRDN) ||
                       ((nxt == RUN) && (state != RUN));
      bus.busy      <= (nxt != OFF) && (nxt != RUN);
    end
  end

`ifdef HFOSC_ONTIME_EN
  always_ff @(posedge clk) begin
    if (reset || ontime_clr)
      hf_ontime <= '0;
    else if (bus.hf_en && (hf_ontime != 32'hFFFF_FFFF))
      hf_ontime <= hf_ontime + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hfosc_sequencer.sv
// Randomized bench: a timeline-level reference model feeds an expected-output queue drained by a negedge monitor.
module tb_hfosc_sequencer;
  localparam int PU = 4;
  localparam int ST = 8;

  typedef struct packed {
    logic        pu;
    logic        en;
    logic        sel;
    logic        hold;
    logic        busy;
    logic        rst;
    logic [31:0] ont;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hfosc_sequencer_if bus ();
`ifdef HFOSC_ONTIME_EN
  logic        ontime_clr;
  logic [31:0] hf_ontime;
`endif

  hfosc_sequencer #(.PU_CYCLES(PU), .SETTLE_CYCLES(ST), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HFOSC_ONTIME_EN
    ,
    .ontime_clr (ontime_clr),
    .hf_ontime  (hf_ontime)
`endif
  );

  exp_t sbq[$];
  int   nvec = 0;
  int   nmis = 0;

  // Reference: output levels evolve on a timeline measured from the moment hf_pu rose.
  bit          m_pu, m_en, m_sel, m_hold, m_busy, m_drain, m_pd;
  int          m_t;
  bit          h0, h1, g0, g1;
  logic [31:0] m_ont = '0;

  task automatic model_step();
    bit   r, i;
    exp_t e;
    if (reset) begin
      {m_pu, m_en, m_sel, m_hold, m_busy, m_drain, m_pd} = '0;
      {h0, h1, g0, g1} = '0;
      m_t   = 0;
      m_ont = '0;
    end else begin
      r  = h1;
      i  = g1;
      h1 = h0;
      h0 = bus.clkhf_powerup & bus.clkhf_enable;
      g1 = g0;
      g0 = bus.core_idle;
`ifdef HFOSC_ONTIME_EN
      if (ontime_clr) m_ont = '0;
      else if (m_en && m_ont != 32'hFFFF_FFFF) m_ont = m_ont + 1;
`endif
      if (m_pd) begin
        m_pu = 0; m_hold = 0; m_busy = 0; m_pd = 0;
      end else if (!m_pu) begin
        if (r) begin m_pu = 1; m_busy = 1; m_t = 0; end
      end else if (!m_sel) begin
        if (!r) begin
          m_en = 0; m_hold = 1; m_pd = 1;
        end else begin
          m_t++;
          if (m_t == PU) begin m_en = 1; m_hold = 1; end
          if (m_t == PU + ST) begin m_sel = 1; m_busy = 0; end
        end
      end else begin
        if (r) begin
          m_hold = m_drain; m_drain = 0; m_busy = 0;
        end else if (!m_drain) begin
          m_drain = 1; m_hold = 1; m_busy = 1;
        end else if (i) begin
          m_sel = 0; m_en = 0; m_hold = 1; m_drain = 0; m_pd = 1;
        end
      end
    end
    e.pu = m_pu; e.en = m_en; e.sel = m_sel; e.hold = m_hold; e.busy = m_busy;
    e.rst = reset;
    e.ont = m_ont;
    sbq.push_back(e);
  endtask

  always @(posedge clk) model_step();

  logic prev_sel = 1'b0;

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act, exp5;
    logic       inv_ok;
    if (sbq.size() == 0) begin
      nmis++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e    = sbq.pop_front();
      act  = {bus.hf_pu, bus.hf_en, bus.hf_sel, bus.core_hold, bus.busy};
      exp5 = {e.pu, e.en, e.sel, e.hold, e.busy};
      nvec++;
      if (act !== exp5) begin
        nmis++;
        $display("FAIL outputs t=%0t {pu,en,sel,hold,busy} got=%b want=%b", $time, act, exp5);
      end
      inv_ok = (!bus.hf_en || bus.hf_pu) && (!bus.hf_sel || bus.hf_en) &&
               (e.rst || (bus.hf_sel == prev_sel) || bus.core_hold);
      nvec++;
      if (inv_ok !== 1'b1) begin
        nmis++;
        $display("FAIL invariants t=%0t pu=%b en=%b sel=%b prev_sel=%b hold=%b",
                 $time, bus.hf_pu, bus.hf_en, bus.hf_sel, prev_sel, bus.core_hold);
      end
`ifdef HFOSC_ONTIME_EN
      nvec++;
      if (hf_ontime !== e.ont) begin
        nmis++;
        $display("FAIL ontime t=%0t got=%0d want=%0d", $time, hf_ontime, e.ont);
      end
`endif
      prev_sel = bus.hf_sel;
    end
  end

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
`ifdef HFOSC_ONTIME_EN
      ontime_clr = ($urandom_range(0, 19) == 0);
`endif
    end
  endtask

  task automatic set_req(input bit pw, input bit en);
    bus.clkhf_powerup = pw;
    bus.clkhf_enable  = en;
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 0);
    bus.core_idle = 1'b0;
`ifdef HFOSC_ONTIME_EN
    ontime_clr = 1'b0;
`endif
    step(2);
    reset = 1'b0;
    step(20);

    // power-on, run, then drain with core busy before shutdown
    set_req(1, 1);
    step(25);
    set_req(1, 0);
    step(10);
    bus.core_idle = 1'b1;
    step(8);

    // abort two cycles after hf_pu rises
    set_req(1, 1);
    step(5);
    set_req(0, 1);
    step(10);

    // re-request while draining
    set_req(1, 1);
    step(20);
    bus.core_idle = 1'b0;
    set_req(0, 0);
    step(5);
    set_req(1, 1);
    step(10);
    set_req(0, 0);
    bus.core_idle = 1'b1;
    step(8);

    // reset while running
    set_req(1, 1);
    step(20);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(20);
    set_req(0, 0);
    step(8);

    for (int k = 0; k < 250; k++) begin
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      bus.core_idle = $urandom_range(0, 1);
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step($urandom_range(1, 24));
    end

    set_req(0, 0);
    bus.core_idle = 1'b1;
    step(10);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
